// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock, with signed
// mode, divide-by-zero detection and a start/done handshake.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg;      // dividend magnitude, becomes quotient bit by bit
  logic [WIDTH-1:0] b_reg;      // divisor magnitude
  logic [WIDTH-1:0] r_reg;      // partial remainder
  logic [CW-1:0]    count_reg;
  logic             sa_reg, sb_reg, zero_reg;
  logic [WIDTH-1:0] quot_reg, rem_reg;
  logic             dz_reg;

  logic             accept;
  logic             div_zero;
  logic             last_iter;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;
  logic             fits;
  logic [WIDTH-1:0] q_fixed, r_fixed;

  always_comb begin
    accept    = start && (state_reg == IDLE || state_reg == DONE);
    div_zero  = (divisor == '0);
    last_iter = (count_reg == CW'(WIDTH - 1));
    // Magnitudes fit in WIDTH unsigned bits, including |MIN| = 2^(WIDTH-1).
    a_mag     = (sgn && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    b_mag     = (sgn && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
    // Partial remainder is always < divisor, so the shifted value is < 2*divisor
    // and bit WIDTH of the difference is a clean borrow indicator.
    shifted   = {r_reg, a_reg[WIDTH-1]};
    diff      = shifted - {1'b0, b_reg};
    fits      = ~diff[WIDTH];
    q_fixed   = (sa_reg ^ sb_reg) ? (~a_reg + 1'b1) : a_reg;
    r_fixed   = sa_reg ? (~r_reg + 1'b1) : r_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (accept) state_next = div_zero ? FIX : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_iter) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (accept) state_next = div_zero ? FIX : CALC;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Divide by zero passes through FIX with the raw dividend parked in a_reg,
  // which gives it the one-cycle-later completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      r_reg     <= '0;
      count_reg <= '0;
      sa_reg    <= 1'b0;
      sb_reg    <= 1'b0;
      zero_reg  <= 1'b0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      dz_reg    <= 1'b0;
    end else if (accept) begin
      a_reg     <= div_zero ? dividend : a_mag;
      b_reg     <= b_mag;
      r_reg     <= '0;
      count_reg <= '0;
      sa_reg    <= sgn && dividend[WIDTH-1];
      sb_reg    <= sgn && divisor[WIDTH-1];
      zero_reg  <= div_zero;
    end else if (state_reg == CALC) begin
      r_reg     <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      a_reg     <= {a_reg[WIDTH-2:0], fits};
      count_reg <= count_reg + 1'b1;
    end else if (state_reg == FIX) begin
      if (zero_reg) begin
        quot_reg <= '1;
        rem_reg  <= a_reg;
        dz_reg   <= 1'b1;
      end else begin
        quot_reg <= q_fixed;
        rem_reg  <= r_fixed;
        dz_reg   <= 1'b0;
      end
    end
  end

  assign quot = quot_reg;
  assign rem  = rem_reg;
  assign dz   = dz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed test of seq_divider: acceptances push expected results into a queue,
// a monitor pops and checks them (value and latency) whenever done is seen.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start, sgn;
  logic [W-1:0] dividend, divisor;
  logic         ready, busy, done, dz;
  logic [W-1:0] quot, rem;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           k;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           acc_cnt = 0;
  int           last_k = 0;
  logic [W-1:0] exp_q, exp_r;
  logic         exp_z;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn),
    .dividend(dividend), .divisor(divisor),
    .ready(ready), .busy(busy), .done(done), .dz(dz),
    .quot(quot), .rem(rem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Acceptance tracker: values sampled here are the pre-edge ones.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (!rst && start && ready) begin
      e.q = exp_q; e.r = exp_r; e.z = exp_z; e.k = cyc;
      e.lat = exp_z ? 1 : W + 1;
      sb.push_back(e);
      acc_cnt++;
      last_k = cyc;
    end
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        $display("result quot=%h rem=%h dz=%b latency=%0d", quot, rem, dz, cyc - e.k);
        chk("quot", quot, e.q);
        chk("rem", rem, e.r);
        chk("dz", dz, e.z);
        chk("latency", cyc - e.k, e.lat);
        chk("done_ready", ready, 1'b1);
      end
    end
  end

  task automatic set_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    sgn = s; dividend = a; divisor = b;
    exp_q = q; exp_r = r; exp_z = z;
  endtask

  task automatic wait_accept();
    int c0 = acc_cnt;
    int n = 0;
    while (acc_cnt == c0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (acc_cnt == c0) chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || !ready || done) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    @(negedge clk);
    set_op(s, a, b, q, r, z);
    start = 1'b1;
    wait_accept();
    start = 1'b0;
    wait_drain();
  endtask

  initial begin
    int k1;
    rst = 1'b1; start = 1'b0;
    set_op(1'b0, '0, '0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dz", dz, 1'b0);
    chk("rst_quot", quot, 16'h0);
    chk("rst_rem", rem, 16'h0);

    run_op(1'b0, 16'd1000, 16'd7,  16'd142,  16'd6,    1'b0);
    run_op(1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0);
    run_op(1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0);
    run_op(1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1);
    run_op(1'b0, 16'd10,   16'd3,    16'd3,    16'd1,    1'b0);
    run_op(1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
    run_op(1'b0, 16'd5,    16'd9,    16'd0,    16'd5,    1'b0);
    run_op(1'b0, 16'hABCD, 16'h0001, 16'hABCD, 16'h0000, 1'b0);
    run_op(1'b1, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0);
    run_op(1'b1, 16'h8000, 16'h0000, 16'hFFFF, 16'h8000, 1'b1);
    run_op(1'b0, 16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF, 1'b0);
    run_op(1'b0, 16'hFFFE, 16'hFFFF, 16'h0000, 16'hFFFE, 1'b0);
    run_op(1'b1, 16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0);

    // start re-pulsed mid-CALC with different operands must be ignored
    @(negedge clk);
    set_op(1'b0, 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0);
    start = 1'b1;
    wait_accept();
    start = 1'b0;
    repeat (4) @(negedge clk);
    dividend = 16'd50; divisor = 16'd5; sgn = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // start held high through DONE: second op accepted on the DONE edge
    @(negedge clk);
    set_op(1'b0, 16'd100, 16'd9, 16'd11, 16'd1, 1'b0);
    start = 1'b1;
    wait_accept();
    k1 = last_k;
    set_op(1'b1, 16'hFFEC, 16'h0003, 16'hFFFA, 16'hFFFE, 1'b0);
    wait_accept();
    start = 1'b0;
    chk("b2b_gap", last_k - k1, W + 2);
    wait_drain();

    // reset at iteration 8 aborts: no done, outputs cleared
    @(negedge clk);
    set_op(1'b0, 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0);
    start = 1'b1;
    wait_accept();
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_quot", quot, 16'h0);
    chk("abort_rem", rem, 16'h0);
    chk("abort_dz", dz, 1'b0);
    chk("abort_ready", ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    repeat (25) @(negedge clk);
    chk("abort_no_done_quot", quot, 16'h0);

    run_op(1'b0, 16'd10, 16'd3, 16'd3, 16'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 want 0");
    $fatal(1, "timeout");
  end

endmodule
